// File: rtl/serial_pkg.sv
// Shared types and constants for the word serializer slice.
package serial_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } shift_state_t;

  // A length of zero, or one larger than the word, means a full-width word.
  function automatic int unsigned norm_len(int unsigned len, int unsigned w);
    return (len == 0 || len > w) ? w : len;
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Upstream word handshake between a word producer and the serializer.
interface word_serializer_if
  #(parameter int W  = serial_pkg::W_DEFAULT,
    parameter int LW = $clog2(W + 1));

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [LW-1:0] in_len;

  modport master (output in_valid, output in_data, output in_len, input in_ready);
  modport slave  (input in_valid, input in_data, input in_len, output in_ready);

endinterface

// File: rtl/serializer_fifo2.sv
// Two-entry FIFO with registered full/empty flags.
module serializer_fifo2
  #(parameter int DW = 21)
  (input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty);

  logic [DW-1:0] mem [2];
  logic          wptr;
  logic          rptr;
  logic [1:0]    count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rdata   = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (do_pop)
        rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Word-to-bit serializer: 2-deep word FIFO feeding an MSB-first shifter
// with registered first/last framing for a bit-serial consumer.
module word_serializer
  import serial_pkg::*;
  #(parameter int W  = W_DEFAULT,
    parameter int LW = $clog2(W + 1))
  (input  logic clk,
   input  logic reset,
   word_serializer_if.slave in_if,
   output logic dout,
   output logic dout_valid,
   output logic dout_first,
   output logic dout_last,
   output logic busy);

  localparam int EW = W + LW;

  logic          alive;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;
  logic [W-1:0]  head_data;
  logic [LW-1:0] head_len;
  logic [LW-1:0] in_len_n;

  shift_state_t  state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          dout_d, valid_d, first_d, last_d;
  logic          load;
  logic [W-1:0]  aligned;
  int unsigned   shamt;

  // alive keeps in_ready low until the first edge after reset release.
  assign in_if.in_ready = alive && !fifo_full;
  assign push           = in_if.in_valid && in_if.in_ready;
  assign in_len_n       = LW'(norm_len(32'(in_if.in_len), 32'(W)));
  assign fifo_wdata     = {in_if.in_data, in_len_n};
  assign {head_data, head_len} = fifo_rdata;
  assign busy           = !fifo_empty || (state_q == SHIFT);

  serializer_fifo2 #(.DW(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    shamt   = 32'(W) - 32'(head_len);
    aligned = head_data << shamt;

    case (state_q)
      IDLE: begin
        if (!fifo_empty)
          load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          valid_d = 1'b1;
          dout_d  = sreg_q[W-1];
          sreg_d  = sreg_q << 1;
          cnt_d   = cnt_q - LW'(1);
          last_d  = (cnt_d == '0);
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading left-aligns the word so the MSB of the valid field leaves first.
    if (load) begin
      pop     = 1'b1;
      state_d = SHIFT;
      valid_d = 1'b1;
      first_d = 1'b1;
      dout_d  = aligned[W-1];
      sreg_d  = aligned << 1;
      cnt_d   = head_len - LW'(1);
      last_d  = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive      <= 1'b0;
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      alive      <= 1'b1;
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      dout_first <= first_d;
      dout_last  <= last_d;
    end
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL provide parameter W, default 16, meaning maximum word width in bits.
REQ-002 SHALL provide derived parameter LW, default $clog2(W+1), meaning length-field width.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  upstream word offered.
REQ-006 SHALL provide port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL provide port in_data  input  W  parallel word; bit in_len-1 is sent first.
REQ-008 SHALL provide port in_len  input  LW  bit count, 1..W; 0 and values above W mean W.
REQ-009 SHALL provide port dout  output  1  serial bit, MSB-first, for a downstream bit-serial remainder checker.
REQ-010 SHALL provide port dout_valid  output  1  dout carries a data bit this cycle.
REQ-011 SHALL provide port dout_first  output  1  current bit is the first bit of a word; the consumer clears its remainder state on it.
REQ-012 SHALL provide port dout_last  output  1  current bit is the last bit of a word.
REQ-013 SHALL provide port busy  output  1  FIFO non-empty or shifter active.

Function
REQ-014 SHALL accept a word on a rising edge where in_valid && in_ready, storing {in_data, normalized len} in a 2-entry FIFO.
REQ-015 SHALL drive in_ready = FIFO not full, registered-state based only, with no combinational path from in_valid.
REQ-016 SHALL, when full, hold in_ready low even if a pop occurs that cycle (no same-cycle pass-through).
REQ-017 SHALL implement shifter FSM states IDLE and SHIFT: IDLE->SHIFT on FIFO non-empty (load head); SHIFT->SHIFT on last bit with FIFO non-empty (reload, zero gap); SHIFT->IDLE on last bit with FIFO empty.
REQ-018 SHALL present a word accepted at edge k with its first bit from edge k+1 when the shifter is IDLE and the FIFO is empty (1-cycle latency).
REQ-019 SHALL emit exactly len bits per word, one per cycle, order in_data[len-1] down to in_data[0].
REQ-020 SHALL register dout, dout_valid, dout_first and dout_last, with no combinational input-to-output path.
REQ-021 SHALL assert dout_first and dout_last together on the single bit of a len=1 word.
REQ-022 SHALL hold dout, dout_first and dout_last at 0 whenever dout_valid is 0.
REQ-023 SHALL use a bit counter of LW bits counting len-1 down to 0 without wrap; dout_last is asserted when the count is 0.
REQ-024 SHALL, on simultaneous push and pop with the FIFO non-full, keep occupancy unchanged and preserve order.
REQ-025 SHALL ignore in_data and in_len when in_valid is low.

Reset
REQ-026 SHALL, on reset assertion and without waiting for clk, force FSM=IDLE, FIFO empty, counter=0, dout=0, dout_valid=0, dout_first=0, dout_last=0, busy=0, in_ready=0.
REQ-027 SHALL drive in_ready=1 from the first rising edge after reset deasserts.
REQ-028 SHALL discard a partially shifted word and all FIFO contents on reset mid-operation, with no residual bits after release.

Structure
REQ-029 SHALL place the state enum (IDLE, SHIFT) and the default W constant in shared package serial_pkg.
REQ-030 SHALL implement the FIFO as sub-module serializer_fifo2 (2 entries, full/empty flags, width W+LW).
REQ-031 SHALL keep the shifter, counter and FSM in word_serializer itself.

Verification
REQ-032 SHALL cover: in_data=0x0005, in_len=3 on an idle block -> dout 1,0,1 on 3 consecutive cycles, first on bit 1, last on bit 3, then dout_valid=0.
REQ-033 SHALL cover: words 0x000A len 4 then 0x0003 len 2, back-to-back -> stream 1,0,1,0,1,1 with no gap, and first asserted on bits 1 and 5.
REQ-034 SHALL cover: in_len=0 with in_data=0x8001 -> 16 bits emitted, 1 then fourteen 0s then 1.
REQ-035 SHALL cover: in_valid held high with 4 words of len 8 -> in_ready drops after 2 accepts plus the shifter load, no word is lost, and 32 bits are emitted in order.
REQ-036 SHALL cover: reset asserted mid-word (bit 2 of 0x00FF len 8) -> dout_valid falls asynchronously, busy=0, and the next word starts cleanly with dout_first.
REQ-037 SHALL cover: with a downstream remainder checker cleared on dout_first, words 5, 10 and 7 -> checker flags 5 and 10 as divisible and does not flag 7.
